// File: rtl/ft_lockstep_checker.sv
// Dual-core lockstep comparator: filters transient core divergence and declares a fault on persistent mismatch.
// On a fault it halts both cores and runs a recovery handshake, then resynchronises.
module ft_lockstep_checker #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MISMATCH_THRESH = 3,
  parameter int unsigned RESYNC_CYCLES   = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] alu_result_c1_i,
  input  logic [DATA_W-1:0] alu_result_c2_i,
  input  logic [DATA_W-1:0] instr_addr_c1_i,
  input  logic [DATA_W-1:0] instr_addr_c2_i,
  input  logic              recover_ack_i,
  input  logic              clear_i,
  output logic              mismatch_o,
  output logic              halt_o,
  output logic              recover_req_o,
  output logic [DATA_W-1:0] fault_pc_o,
  output logic [CNT_W-1:0]  fault_count_o,
  output logic [CNT_W-1:0]  transient_count_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    SUSPECT = 3'd2,
    FAULT   = 3'd3,
    RESYNC  = 3'd4
  } state_t;

  localparam logic [3:0] THRESH = 4'(MISMATCH_THRESH);
  localparam logic [7:0] RSYNC  = 8'(RESYNC_CYCLES);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [7:0]        rcnt, rcnt_next;
  logic              mis, mis_reg;
  logic              capture, fault_inc, trans_inc;
  logic [DATA_W-1:0] fault_pc;
  logic [CNT_W-1:0]  fault_cnt, trans_cnt;

  assign mis = (alu_result_c1_i != alu_result_c2_i) || (instr_addr_c1_i != instr_addr_c2_i);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rcnt_next  = rcnt;
    capture    = 1'b0;
    trans_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable_i) state_next = CHECK;
      end
      CHECK: begin
        if (!enable_i) begin
          state_next = IDLE;
        end else if (mis) begin
          capture    = 1'b1;
          cnt_next   = 4'd1;
          state_next = (THRESH == 4'd1) ? FAULT : SUSPECT;
        end
      end
      SUSPECT: begin
        // enable_i wins even over the threshold-reaching mismatch
        if (!enable_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (mis) begin
          cnt_next = cnt + 4'd1;
          if ((cnt + 4'd1) == THRESH) state_next = FAULT;
        end else begin
          state_next = CHECK;
          cnt_next   = '0;
          trans_inc  = 1'b1;
        end
      end
      FAULT: begin
        cnt_next = '0;
        if (recover_ack_i) begin
          if (RSYNC == 8'd0) begin
            state_next = CHECK;
          end else begin
            state_next = RESYNC;
            rcnt_next  = RSYNC;
          end
        end
      end
      RESYNC: begin
        rcnt_next = rcnt - 8'd1;
        if (rcnt == 8'd1) begin
          state_next = enable_i ? CHECK : IDLE;
          rcnt_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fault_inc = (state_next == FAULT) && (state != FAULT);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      mis_reg   <= 1'b0;
      fault_pc  <= '0;
      fault_cnt <= '0;
      trans_cnt <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rcnt    <= rcnt_next;
      mis_reg <= mis && (state != IDLE) && (state != RESYNC);
      if (capture) fault_pc <= instr_addr_c1_i;
      if (clear_i) begin
        fault_cnt <= '0;
        trans_cnt <= '0;
      end else begin
        if (fault_inc && (fault_cnt != '1)) fault_cnt <= fault_cnt + 1'b1;
        if (trans_inc && (trans_cnt != '1)) trans_cnt <= trans_cnt + 1'b1;
      end
    end
  end

  // Gated again on the present state so the flag is never seen in IDLE/RESYNC,
  // including the first RESYNC cycle that follows a mismatching FAULT cycle.
  assign mismatch_o        = mis_reg && (state != IDLE) && (state != RESYNC);
  assign halt_o            = (state == FAULT);
  assign recover_req_o     = (state == FAULT);
  assign fault_pc_o        = fault_pc;
  assign fault_count_o     = fault_cnt;
  assign transient_count_o = trans_cnt;
  assign state_o           = state;

endmodule

// File: tb/tb_ft_lockstep_checker.sv
// Directed bench for ft_lockstep_checker (THRESH=3, RESYNC=4, CNT_W=2 for saturation).
module tb_ft_lockstep_checker;

  logic        clk = 1'b0;
  logic        rst_n, enable, recover_ack, clear;
  logic [31:0] alu1, alu2, ia1, ia2;
  logic        mismatch, halt, recover_req;
  logic [31:0] fault_pc;
  logic [1:0]  fault_count, transient_count;
  logic [2:0]  state;
  int          checks = 0;
  int          errors = 0;

  ft_lockstep_checker #(
    .DATA_W(32), .MISMATCH_THRESH(3), .RESYNC_CYCLES(4), .CNT_W(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .alu_result_c1_i(alu1), .alu_result_c2_i(alu2),
    .instr_addr_c1_i(ia1), .instr_addr_c2_i(ia2),
    .recover_ack_i(recover_ack), .clear_i(clear),
    .mismatch_o(mismatch), .halt_o(halt), .recover_req_o(recover_req),
    .fault_pc_o(fault_pc), .fault_count_o(fault_count),
    .transient_count_o(transient_count), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mis(input logic on);
    alu1 = 32'h10;
    alu2 = on ? 32'h14 : 32'h10;
  endtask

  // From FAULT: ack, 4 RESYNC cycles, CHECK, then SUSPECT on the continued mismatch.
  task automatic recover_to_suspect();
    recover_ack = 1'b1;
    step();
    recover_ack = 1'b0;
    check("rs_enter", 32'(state), 32'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rs_hold", 32'(state), 32'd4);
    end
    step();
    check("rs_exit", 32'(state), 32'd1);
    step();
    check("rs_suspect", 32'(state), 32'd2);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; recover_ack = 1'b0; clear = 1'b0;
    alu1 = 32'h1; alu2 = 32'h2; ia1 = 32'h0; ia2 = 32'h0;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_req", 32'(recover_req), 32'd0);
    check("rst_mis", 32'(mismatch), 32'd0);
    check("rst_pc", fault_pc, 32'd0);
    check("rst_fc", 32'(fault_count), 32'd0);
    check("rst_tc", 32'(transient_count), 32'd0);

    rst_n = 1'b1; set_mis(1'b0);
    step();
    check("idle_to_check", 32'(state), 32'd1);

    // transient: two mismatching cycles then equal
    set_mis(1'b1); ia1 = 32'h40; ia2 = 32'h40;
    step();
    check("tr_s1", 32'(state), 32'd2);
    check("tr_mis", 32'(mismatch), 32'd1);
    step();
    check("tr_s2", 32'(state), 32'd2);
    check("tr_halt", 32'(halt), 32'd0);
    set_mis(1'b0);
    step();
    check("tr_back", 32'(state), 32'd1);
    check("tr_mis0", 32'(mismatch), 32'd0);
    check("tr_tc", 32'(transient_count), 32'd1);
    check("tr_fc", 32'(fault_count), 32'd0);

    // fault declaration, pc captured at first mismatch only
    set_mis(1'b1); ia1 = 32'h80; ia2 = 32'h80;
    step();
    check("f_s1", 32'(state), 32'd2);
    check("f_pc1", fault_pc, 32'h80);
    ia1 = 32'h84; ia2 = 32'h84;
    step();
    check("f_halt_pre", 32'(halt), 32'd0);
    step();
    check("f_state", 32'(state), 32'd3);
    check("f_halt", 32'(halt), 32'd1);
    check("f_req", 32'(recover_req), 32'd1);
    check("f_pc", fault_pc, 32'h80);
    check("f_fc", 32'(fault_count), 32'd1);

    // sticky FAULT
    set_mis(1'b0); enable = 1'b0;
    step();
    check("f_sticky", 32'(state), 32'd3);
    check("f_sticky_h", 32'(halt), 32'd1);
    set_mis(1'b1); enable = 1'b1;
    step();
    check("f_sticky2", 32'(state), 32'd3);
    check("f_mis", 32'(mismatch), 32'd1);

    // recovery with inputs still mismatching
    recover_ack = 1'b1;
    step();
    recover_ack = 1'b0;
    check("rc_state", 32'(state), 32'd4);
    check("rc_halt", 32'(halt), 32'd0);
    check("rc_req", 32'(recover_req), 32'd0);
    check("rc_mis", 32'(mismatch), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rc_hold", 32'(state), 32'd4);
      check("rc_hold_mis", 32'(mismatch), 32'd0);
    end
    step();
    check("rc_check", 32'(state), 32'd1);
    check("rc_check_mis", 32'(mismatch), 32'd0);
    step();
    check("rc_suspect", 32'(state), 32'd2);
    check("rc_pc", fault_pc, 32'h84);
    check("rc_fc", 32'(fault_count), 32'd1);

    // second and third fault, then a fourth with ack held through SUSPECT
    step(); step();
    check("ep2_state", 32'(state), 32'd3);
    check("ep2_fc", 32'(fault_count), 32'd2);
    recover_to_suspect();
    step(); step();
    check("ep3_fc", 32'(fault_count), 32'd3);
    recover_to_suspect();
    recover_ack = 1'b1;
    step();
    check("ep4_ack_ign", 32'(state), 32'd2);
    step();
    check("ep4_state", 32'(state), 32'd3);
    check("ep4_sat", 32'(fault_count), 32'd3);
    recover_ack = 1'b0;

    // clear coinciding with a transient increment
    recover_to_suspect();
    check("cl_tc_pre", 32'(transient_count), 32'd1);
    set_mis(1'b0); clear = 1'b1;
    step();
    clear = 1'b0;
    check("cl_state", 32'(state), 32'd1);
    check("cl_tc", 32'(transient_count), 32'd0);
    check("cl_fc", 32'(fault_count), 32'd0);

    // enable drop beats the threshold-reaching mismatch
    set_mis(1'b1);
    step(); step();
    check("en_cnt2", 32'(state), 32'd2);
    enable = 1'b0;
    step();
    check("en_idle", 32'(state), 32'd0);
    check("en_mis", 32'(mismatch), 32'd0);
    check("en_fc", 32'(fault_count), 32'd0);
    check("en_tc", 32'(transient_count), 32'd0);
    enable = 1'b1;
    step();
    check("en_check", 32'(state), 32'd1);

    // reset mid-FAULT
    step(); step(); step();
    check("rf_halt_pre", 32'(halt), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rf_halt", 32'(halt), 32'd0);
    check("rf_pc", fault_pc, 32'd0);
    check("rf_state", 32'(state), 32'd0);
    check("rf_fc", 32'(fault_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
